bpfcpu_dispatch: RTL and testbench

Parametrised packet dispatcher for a pool of N_CORES BPF CPU cores, successor to the single-core CPU wrapper. Accepts packet descriptors (buffer address and length) over a valid/ready handshake and hands each one to a free core with a round-robin choice. Tracks each core through a per-core state machine and enforces a per-packet cycle budget. Returns filter verdicts, tagged with core index and packet address, over a second valid/ready handshake. Sits between the packet-buffer manager and the core array.

---
 rtl/bpfcpu_dispatch.sv | 229 ++++++++++++++++++++++
 tb/tb_bpfcpu_dispatch.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bpfcpu_dispatch.sv
// Round-robin packet dispatcher for a pool of BPF cores: per-core run tracking,
// per-packet cycle budget and a single registered verdict output.
module bpfcpu_dispatch #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 16,
  parameter int RES_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          pkt_valid,
  output logic                                          pkt_ready,
  input  logic [ADDR_W-1:0]                             pkt_addr,
  input  logic [LEN_W-1:0]                              pkt_len,
  output logic [N_CORES-1:0]                            core_start,
  output logic [N_CORES-1:0]                            core_abort,
  output logic [N_CORES*ADDR_W-1:0]                     core_pkt_addr,
  output logic [N_CORES*LEN_W-1:0]                      core_pkt_len,
  input  logic [N_CORES-1:0]                            core_done,
  input  logic [N_CORES*RES_W-1:0]                      core_result,
  output logic [N_CORES-1:0]                            busy,
  output logic                                          res_valid,
  input  logic                                          res_ready,
  output logic [((N_CORES > 1) ? $clog2(N_CORES) : 1)-1:0] res_core,
  output logic [ADDR_W-1:0]                             res_addr,
  output logic [RES_W-1:0]                              res_snaplen,
  output logic                                          res_accept,
  output logic                                          res_timeout
);

  localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : TMR_W'(0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CORES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } core_state_e;

  // Returns {found, index} of the first requester at or after ptr, wrapping.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_CORES-1:0] req,
                                             input logic [IDX_W-1:0]   ptr);
    logic [IDX_W:0]   sel;
    logic [IDX_W-1:0] ix;
    int               idx;
    sel = '0;
    for (int k = N_CORES - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_CORES) idx = idx - N_CORES;
      ix = IDX_W'(idx);
      if (req[ix]) sel = {1'b1, ix};
    end
    return sel;
  endfunction

  function automatic logic [IDX_W-1:0] ptr_next(input logic [IDX_W-1:0] p);
    return (p == IDX_LAST) ? '0 : p + 1'b1;
  endfunction

  core_state_e          state_q [N_CORES];
  core_state_e          state_d [N_CORES];
  logic [TMR_W-1:0]     timer_q [N_CORES];
  logic [TMR_W-1:0]     timer_d [N_CORES];
  logic [ADDR_W-1:0]    addr_q  [N_CORES];
  logic [ADDR_W-1:0]    addr_d  [N_CORES];
  logic [LEN_W-1:0]     len_q   [N_CORES];
  logic [LEN_W-1:0]     len_d   [N_CORES];
  logic [RES_W-1:0]     cres_q  [N_CORES];
  logic [RES_W-1:0]     cres_d  [N_CORES];
  logic [N_CORES-1:0]   to_q, to_d;
  logic [N_CORES-1:0]   start_q, start_d;
  logic [N_CORES-1:0]   abort_q, abort_d;
  logic [IDX_W-1:0]     in_ptr_q, in_ptr_d;
  logic [IDX_W-1:0]     out_ptr_q, out_ptr_d;

  logic                 rvalid_q, rvalid_d;
  logic [IDX_W-1:0]     rcore_q, rcore_d;
  logic [ADDR_W-1:0]    raddr_q, raddr_d;
  logic [RES_W-1:0]     rsnap_q, rsnap_d;
  logic                 raccept_q, raccept_d;
  logic                 rtimeout_q, rtimeout_d;

  logic [N_CORES-1:0]   idle_vec, done_vec;
  logic                 disp_found, load_found;
  logic [IDX_W-1:0]     disp_idx, load_idx;
  logic                 hs, load_en;

  always_comb begin
    idle_vec      = '0;
    done_vec      = '0;
    busy          = '0;
    core_pkt_addr = '0;
    core_pkt_len  = '0;
    for (int i = 0; i < N_CORES; i++) begin
      idle_vec[i] = (state_q[i] == S_IDLE);
      done_vec[i] = (state_q[i] == S_DONE);
      busy[i]     = (state_q[i] != S_IDLE);
      core_pkt_addr[i*ADDR_W +: ADDR_W] = addr_q[i];
      core_pkt_len[i*LEN_W +: LEN_W]    = len_q[i];
    end
  end

  assign {disp_found, disp_idx} = rr_pick(idle_vec, in_ptr_q);
  assign {load_found, load_idx} = rr_pick(done_vec, out_ptr_q);

  assign pkt_ready = |idle_vec;
  assign hs        = pkt_valid && disp_found;
  // The verdict register refills in the same cycle it drains.
  assign load_en   = load_found && (!rvalid_q || res_ready);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cres_d     = cres_q;
    to_d       = to_q;
    start_d    = '0;
    abort_d    = '0;
    in_ptr_d   = in_ptr_q;
    out_ptr_d  = out_ptr_q;
    rvalid_d   = rvalid_q;
    rcore_d    = rcore_q;
    raddr_d    = raddr_q;
    rsnap_d    = rsnap_q;
    raccept_d  = raccept_q;
    rtimeout_d = rtimeout_q;

    for (int i = 0; i < N_CORES; i++) begin
      case (state_q[i])
        S_IDLE: begin
          if (hs && disp_idx == IDX_W'(i)) begin
            state_d[i] = S_RUN;
            addr_d[i]  = pkt_addr;
            len_d[i]   = pkt_len;
            timer_d[i] = '0;
            start_d[i] = 1'b1;
          end
        end
        S_RUN: begin
          if (timer_q[i] != TMR_MAX) timer_d[i] = timer_q[i] + 1'b1;
          // A done arriving on the expiry cycle takes precedence.
          if (core_done[i]) begin
            state_d[i] = S_DONE;
            cres_d[i]  = core_result[i*RES_W +: RES_W];
            to_d[i]    = 1'b0;
          end else if (TIMEOUT > 0 && timer_q[i] == TMR_LAST) begin
            state_d[i] = S_DONE;
            cres_d[i]  = '0;
            to_d[i]    = 1'b1;
            abort_d[i] = 1'b1;
          end
        end
        S_DONE: begin
          if (load_en && load_idx == IDX_W'(i)) state_d[i] = S_IDLE;
        end
        default: state_d[i] = S_IDLE;
      endcase
    end

    if (hs) in_ptr_d = ptr_next(disp_idx);

    if (load_en) begin
      rvalid_d   = 1'b1;
      rcore_d    = load_idx;
      raddr_d    = addr_q[load_idx];
      rsnap_d    = cres_q[load_idx];
      raccept_d  = |cres_q[load_idx];
      rtimeout_d = to_q[load_idx];
      out_ptr_d  = ptr_next(load_idx);
    end else if (res_ready) begin
      rvalid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CORES; i++) begin
        state_q[i] <= S_IDLE;
        timer_q[i] <= '0;
        addr_q[i]  <= '0;
        len_q[i]   <= '0;
        cres_q[i]  <= '0;
      end
      to_q       <= '0;
      start_q    <= '0;
      abort_q    <= '0;
      in_ptr_q   <= '0;
      out_ptr_q  <= '0;
      rvalid_q   <= 1'b0;
      rcore_q    <= '0;
      raddr_q    <= '0;
      rsnap_q    <= '0;
      raccept_q  <= 1'b0;
      rtimeout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cres_q     <= cres_d;
      to_q       <= to_d;
      start_q    <= start_d;
      abort_q    <= abort_d;
      in_ptr_q   <= in_ptr_d;
      out_ptr_q  <= out_ptr_d;
      rvalid_q   <= rvalid_d;
      rcore_q    <= rcore_d;
      raddr_q    <= raddr_d;
      rsnap_q    <= rsnap_d;
      raccept_q  <= raccept_d;
      rtimeout_q <= rtimeout_d;
    end
  end

  assign core_start  = start_q;
  assign core_abort  = abort_q;
  assign res_valid   = rvalid_q;
  assign res_core    = rcore_q;
  assign res_addr    = raddr_q;
  assign res_snaplen = rsnap_q;
  assign res_accept  = raccept_q;
  assign res_timeout = rtimeout_q;

endmodule

// File: tb/tb_bpfcpu_dispatch.sv
// Randomized bench for bpfcpu_dispatch: emulated cores, scripted corner cases,
// and a timestamp-based reference model of dispatch, budget and verdict order.
module tb_bpfcpu_dispatch;
  localparam int NC = 4, AW = 32, LW = 16, RW = 32, TO = 16;
  localparam int NCYC = 3000, RST_CYC = 1500;
  localparam int PH_FREE = 0, PH_EXEC = 1, PH_VERD = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              pkt_valid, pkt_ready;
  logic [AW-1:0]     pkt_addr;
  logic [LW-1:0]     pkt_len;
  logic [NC-1:0]     core_start, core_abort, core_done, busy;
  logic [NC*AW-1:0]  core_pkt_addr;
  logic [NC*LW-1:0]  core_pkt_len;
  logic [NC*RW-1:0]  core_result;
  logic              res_valid, res_ready, res_accept, res_timeout;
  logic [1:0]        res_core;
  logic [AW-1:0]     res_addr;
  logic [RW-1:0]     res_snaplen;

  always #5 clk = ~clk;

  bpfcpu_dispatch #(.N_CORES(NC), .ADDR_W(AW), .LEN_W(LW), .RES_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_addr(pkt_addr), .pkt_len(pkt_len), .core_start(core_start),
    .core_abort(core_abort), .core_pkt_addr(core_pkt_addr), .core_pkt_len(core_pkt_len),
    .core_done(core_done), .core_result(core_result), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_core(res_core),
    .res_addr(res_addr), .res_snaplen(res_snaplen), .res_accept(res_accept),
    .res_timeout(res_timeout)
  );

  int n_chk = 0, n_fail = 0, edge_n = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, act, exp, edge_n);
    end
  endtask

  // Reference model: per-core occupancy with dispatch timestamps.
  int            m_ph [NC];
  int            m_t0 [NC];
  logic [AW-1:0] m_addr [NC];
  logic [LW-1:0] m_len [NC];
  logic [RW-1:0] m_res [NC];
  bit            m_to [NC];
  int            m_in, m_out;
  bit            e_rv, e_to;
  int            e_core;
  logic [AW-1:0] e_addr;
  logic [RW-1:0] e_snap;
  logic [NC-1:0] e_start, e_abort;

  // Core emulation and descriptor source.
  int            done_at [NC];
  logic [RW-1:0] done_val [NC];
  bit            d_pend, in_rst;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_len;
  int            scr_i;
  int            scr_delay [4] = '{10, 99, 16, 2};
  logic [RW-1:0] scr_res [4]   = '{32'h40, 32'h0, 32'h20, 32'h0};

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_ph[i] = PH_FREE; m_t0[i] = 0; m_addr[i] = '0; m_len[i] = '0;
      m_res[i] = '0; m_to[i] = 1'b0; done_at[i] = -1; done_val[i] = '0;
    end
    m_in = 0; m_out = 0;
    e_rv = 1'b0; e_to = 1'b0; e_core = 0; e_addr = '0; e_snap = '0;
    e_start = '0; e_abort = '0;
  endtask

  function automatic bit bp_window(input int e);
    return (e >= 300 && e < 420) || (e >= 2000 && e < 2100);
  endfunction

  task automatic compare_all(input bit full);
    bit any_free;
    logic [NC-1:0] exp_busy;
    any_free = 1'b0;
    for (int i = 0; i < NC; i++) begin
      exp_busy[i] = (m_ph[i] != PH_FREE);
      if (m_ph[i] == PH_FREE) any_free = 1'b1;
    end
    chk("pkt_ready", pkt_ready, any_free);
    chk("core_start", core_start, e_start);
    chk("core_abort", core_abort, e_abort);
    chk("busy", busy, exp_busy);
    chk("res_valid", res_valid, e_rv);
    if (e_rv || full) begin
      chk("res_core", res_core, e_core);
      chk("res_addr", res_addr, e_addr);
      chk("res_snaplen", res_snaplen, e_snap);
      chk("res_accept", res_accept, e_snap != '0);
      chk("res_timeout", res_timeout, e_to);
    end
    for (int i = 0; i < NC; i++) begin
      chk("core_pkt_addr", core_pkt_addr[i*AW +: AW], m_addr[i]);
      chk("core_pkt_len", core_pkt_len[i*LW +: LW], m_len[i]);
    end
  endtask

  task automatic drive_inputs();
    logic [RW-1:0] v;
    bit bp;
    bp = bp_window(edge_n);
    if (!d_pend && (bp || $urandom_range(0, 9) < 7)) begin
      d_pend = 1'b1; d_addr = $urandom; d_len = LW'($urandom);
    end
    pkt_valid = d_pend;
    pkt_addr  = d_addr;
    pkt_len   = d_len;
    res_ready = bp ? 1'b0 : ($urandom_range(0, 3) != 0);
    for (int i = 0; i < NC; i++) begin
      v = ($urandom_range(0, 3) == 0) ? '0 : RW'($urandom);
      if (done_at[i] == edge_n) begin
        core_done[i] = 1'b1; v = done_val[i];
      end else begin
        core_done[i] = ($urandom_range(0, 39) == 0);
      end
      core_result[i*RW +: RW] = v;
    end
  endtask

  task automatic model_edge();
    int pick_in, pick_out, j, d;
    bit hs, load;
    pick_in = -1; pick_out = -1;
    for (int k = 0; k < NC; k++) begin
      j = (m_in + k) % NC;
      if (pick_in < 0 && m_ph[j] == PH_FREE) pick_in = j;
      j = (m_out + k) % NC;
      if (pick_out < 0 && m_ph[j] == PH_VERD) pick_out = j;
    end
    hs   = pkt_valid && (pick_in >= 0);
    load = (pick_out >= 0) && (!e_rv || res_ready);
    e_start = '0; e_abort = '0;
    if (load) begin
      e_rv = 1'b1; e_core = pick_out; e_addr = m_addr[pick_out];
      e_snap = m_res[pick_out]; e_to = m_to[pick_out];
      m_ph[pick_out] = PH_FREE; m_out = (pick_out + 1) % NC;
    end else if (res_ready) begin
      e_rv = 1'b0;
    end
    for (int i = 0; i < NC; i++) begin
      if (m_ph[i] == PH_EXEC) begin
        if (core_done[i]) begin
          m_ph[i] = PH_VERD; m_res[i] = core_result[i*RW +: RW]; m_to[i] = 1'b0;
        end else if (edge_n - m_t0[i] == TO) begin
          m_ph[i] = PH_VERD; m_res[i] = '0; m_to[i] = 1'b1; e_abort[i] = 1'b1;
        end
      end
    end
    if (hs) begin
      m_ph[pick_in] = PH_EXEC; m_t0[pick_in] = edge_n;
      m_addr[pick_in] = pkt_addr; m_len[pick_in] = pkt_len;
      e_start[pick_in] = 1'b1; m_in = (pick_in + 1) % NC;
      d_pend = 1'b0;
      if (scr_i < 4) begin
        d = scr_delay[scr_i]; done_val[pick_in] = scr_res[scr_i]; scr_i++;
      end else begin
        d = $urandom_range(1, 20);
        done_val[pick_in] = ($urandom_range(0, 3) == 0) ? '0 : RW'($urandom);
      end
      done_at[pick_in] = (d > TO) ? -1 : edge_n + d;
    end
  endtask

  initial begin
    rst = 1'b0; pkt_valid = 1'b0; pkt_addr = '0; pkt_len = '0;
    core_done = '0; core_result = '0; res_ready = 1'b0;
    d_pend = 1'b0; d_addr = '0; d_len = '0; scr_i = 0;
    model_reset();
    in_rst = 1'b1;
    repeat (3) @(negedge clk);
    compare_all(1'b1);
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      if (in_rst) begin
        rst = 1'b1; in_rst = 1'b0;
      end
      compare_all(1'b0);
      if (c == RST_CYC) begin
        rst = 1'b0;
        #1;
        model_reset();
        d_pend = 1'b0; pkt_valid = 1'b0; core_done = '0;
        compare_all(1'b1);
        in_rst = 1'b1;
      end else begin
        drive_inputs();
        model_edge();
        edge_n++;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
